poly_sub_seq: RTL and testbench



---
 rtl/kyber_pkg.sv | 16 +
 rtl/poly_mod_diff.sv | 36 +++
 rtl/poly_sub_seq.sv | 111 +++++++++++
 tb/tb_poly_sub_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the subtraction sequencer's FSM state encoding.
// Ports: none (package only).
// Imported by poly_sub_seq and poly_mod_diff.
package kyber_pkg;

  localparam int Q       = 3329;
  localparam int COEF_W  = 12;
  localparam int N_COEF  = 256;
  localparam int COEF_AW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/poly_mod_diff.sv
// Combinational modular difference: o_diff = (i_a - i_b) mod Q.
// Ports: i_a, i_b operands (WIDTH bits); o_diff result (WIDTH+1 bits, MSB always 0).
// Zero latency; no handshake, purely combinational.
module poly_mod_diff
  import kyber_pkg::*;
#(
  parameter int WIDTH = COEF_W
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_diff
);

  // Two extra bits: a + 2Q can exceed 2^(WIDTH+1) for out-of-range inputs.
  localparam int DW = WIDTH + 2;
  localparam logic [DW-1:0] L_Q  = DW'(Q);
  localparam logic [DW-1:0] L_2Q = DW'(2 * Q);

  logic [DW-1:0] w_d0;
  logic [DW-1:0] w_d1;
  logic [DW-1:0] w_d2;
  logic [DW-1:0] w_d3;
  logic          w_unused_d3_msb;

  // Adding 2Q before subtracting keeps the value non-negative for any b < 2^WIDTH.
  assign w_d0 = DW'(i_a) + L_2Q - DW'(i_b);

  // Three conditional subtractions bring anything below 4Q into [0, Q-1].
  assign w_d1 = (w_d0 >= L_Q) ? (w_d0 - L_Q) : w_d0;
  assign w_d2 = (w_d1 >= L_Q) ? (w_d1 - L_Q) : w_d1;
  assign w_d3 = (w_d2 >= L_Q) ? (w_d2 - L_Q) : w_d2;

  assign o_diff          = w_d3[WIDTH:0];
  assign w_unused_d3_msb = w_d3[DW-1];

endmodule

// File: rtl/poly_sub_seq.sv
// Sequences r[i] = (a[i] - b[i]) mod Q over a whole polynomial, one coefficient per cycle.
// Ports: clk/rst, start/busy/done to the controller; rd_en/rd_addr/a_coef/b_coef to the operand RAMs;
//        wr_en/wr_addr/wr_data to the result RAM. Read-to-write latency RD_LAT+1; start to done N+RD_LAT+2.
module poly_sub_seq
  import kyber_pkg::*;
#(
  parameter int N      = N_COEF,
  parameter int AW     = COEF_AW,
  parameter int WIDTH  = COEF_W,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] a_coef,
  input  logic [WIDTH-1:0] b_coef,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [AW-1:0]            r_cnt;
  logic [RD_LAT-1:0]        r_vld;
  logic [RD_LAT-1:0][AW-1:0] r_tag;
  logic                     r_wr_en;
  logic [AW-1:0]            r_wr_addr;
  logic [WIDTH-1:0]         r_wr_data;

  logic                     w_rd_en;
  logic                     w_last_rd;
  logic                     w_pipe_empty;
  logic [WIDTH:0]           w_diff;
  logic                     w_unused_diff_msb;

  assign w_rd_en      = (r_state == ST_READ);
  // End of the read burst is decoded from the index, not from the counter wrapping.
  assign w_last_rd    = w_rd_en && (r_cnt == AW'(N - 1));
  assign w_pipe_empty = (r_vld == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)        w_state_nxt = ST_READ;
      ST_READ:  if (w_last_rd)    w_state_nxt = ST_DRAIN;
      // Once the delay line is empty, the last tag emerged a cycle ago and its
      // write is on the outputs this cycle.
      ST_DRAIN: if (w_pipe_empty) w_state_nxt = ST_DONE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  poly_mod_diff #(
    .WIDTH(WIDTH)
  ) u_mod_diff (
    .i_a   (a_coef),
    .i_b   (b_coef),
    .o_diff(w_diff)
  );

  // MSB of the difference is zero by construction of the reduction.
  assign w_unused_diff_msb = w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_vld     <= '0;
      r_tag     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_IDLE) && start) begin
        r_cnt <= '0;
      end else if (w_rd_en) begin
        r_cnt <= r_cnt + AW'(1);
      end

      // Tag each read with its index so the write side needs no counter of its own.
      r_vld[0] <= w_rd_en;
      r_tag[0] <= r_cnt;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end

      r_wr_en <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) begin
        r_wr_addr <= r_tag[RD_LAT-1];
        r_wr_data <= w_diff[WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign rd_en   = w_rd_en;
  assign rd_addr = w_rd_en ? r_cnt : '0;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_poly_sub_seq.sv
// Bench for poly_sub_seq: two instances (RD_LAT=1 and RD_LAT=3) share clk/rst/start,
// each with its own operand-RAM read model; a timeline model predicts every output every cycle.
module tb_poly_sub_seq;

  localparam int NC = 256;
  localparam int QQ = 3329;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic        busy_s    [2];
  logic        done_s    [2];
  logic        rd_en_s   [2];
  logic [7:0]  rd_addr_s [2];
  logic [11:0] a_s       [2];
  logic [11:0] b_s       [2];
  logic        wr_en_s   [2];
  logic [7:0]  wr_addr_s [2];
  logic [11:0] wr_data_s [2];

  logic [11:0] mem_a [NC];
  logic [11:0] mem_b [NC];

  int total = 0;
  int bad   = 0;

  // Model / observation state per instance.
  int          cyc = 0;
  bit          active   [2];
  int          s_cyc    [2];
  int          ops      [2];
  int          wr_cnt   [2];
  int          first_wr [2];
  int          done_k   [2];
  int          done_cnt [2];
  logic [11:0] got      [2][NC];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int mdiff(input int a, input int b);
    int d;
    d = (a - b) % QQ;
    if (d < 0) d += QQ;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [23:0] r_dq [L];

    // Operand RAM read model: data for rd_addr appears L cycles later.
    always @(posedge clk) begin
      r_dq[0] <= {mem_a[rd_addr_s[g]], mem_b[rd_addr_s[g]]};
      for (int k = 1; k < L; k++) r_dq[k] <= r_dq[k-1];
    end
    assign a_s[g] = r_dq[L-1][23:12];
    assign b_s[g] = r_dq[L-1][11:0];

    poly_sub_seq #(
      .N(NC), .AW(8), .WIDTH(12), .RD_LAT(L)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .busy   (busy_s[g]),
      .done   (done_s[g]),
      .rd_en  (rd_en_s[g]),
      .rd_addr(rd_addr_s[g]),
      .a_coef (a_s[g]),
      .b_coef (b_s[g]),
      .wr_en  (wr_en_s[g]),
      .wr_addr(wr_addr_s[g]),
      .wr_data(wr_data_s[g])
    );
  end

  // Compare process: outputs as a function of cycles since start acceptance.
  initial begin
    int L, k;
    bit inop, e_busy, e_done, e_rd, e_wr;
    logic [7:0]  e_ra, e_wa;
    logic [11:0] e_wd;
    for (int g = 0; g < 2; g++) begin
      active[g] = 0; s_cyc[g] = 0; ops[g] = 0; wr_cnt[g] = 0;
      first_wr[g] = -1; done_k[g] = -1; done_cnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        L    = lat_of(g);
        k    = cyc - s_cyc[g];
        inop = active[g] && (k <= NC + L + 2);
        if (!rst) begin
          e_busy = inop && (k >= 1);
          e_done = inop && (k == NC + L + 2);
          e_rd   = inop && (k >= 1) && (k <= NC);
          e_ra   = e_rd ? 8'(k - 1) : 8'd0;
          e_wr   = inop && (k >= L + 2) && (k <= NC + L + 1);
          e_wa   = e_wr ? 8'(k - L - 2) : 8'd0;
          e_wd   = e_wr ? 12'(mdiff(int'(mem_a[e_wa]), int'(mem_b[e_wa]))) : 12'd0;
          chk($sformatf("cycle_lat%0d", L),
              {busy_s[g], done_s[g], rd_en_s[g], rd_en_s[g] ? rd_addr_s[g] : 8'd0,
               wr_en_s[g], wr_en_s[g] ? wr_addr_s[g] : 8'd0, wr_en_s[g] ? wr_data_s[g] : 12'd0},
              {e_busy, e_done, e_rd, e_ra, e_wr, e_wa, e_wd});
          if (wr_en_s[g]) begin
            got[g][wr_addr_s[g]] = wr_data_s[g];
            wr_cnt[g]++;
            if (first_wr[g] < 0) first_wr[g] = k;
          end
          if (done_s[g]) begin
            done_k[g] = k;
            done_cnt[g]++;
          end
        end
        if (rst) begin
          active[g] = 0;
        end else if (start && !inop) begin
          active[g] = 1; s_cyc[g] = cyc; ops[g]++;
          wr_cnt[g] = 0; first_wr[g] = -1; done_k[g] = -1;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int b0, b1, n;
    b0 = done_cnt[0]; b1 = done_cnt[1]; n = 0;
    while (((done_cnt[0] == b0) || (done_cnt[1] == b1)) && (n < 800)) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_in_time"}, 32'(n < 800), 32'd1);
    tick();
  endtask

  task automatic run_op(input string nm);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(nm);
  endtask

  task automatic check_run(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_wrcnt_lat%0d", nm, lat_of(g)), 32'(wr_cnt[g]), 32'd256);
      chk($sformatf("%s_firstwr_lat%0d", nm, lat_of(g)), 32'(first_wr[g]), 32'(lat_of(g) + 2));
      chk($sformatf("%s_donek_lat%0d", nm, lat_of(g)), 32'(done_k[g]), 32'(256 + lat_of(g) + 2));
    end
  endtask

  task automatic check_zero(input string nm);
    for (int g = 0; g < 2; g++)
      chk($sformatf("%s_lat%0d", nm, lat_of(g)),
          {busy_s[g], done_s[g], rd_en_s[g], rd_addr_s[g], wr_en_s[g], wr_addr_s[g], wr_data_s[g]},
          32'd0);
  endtask

  int corner_a [5] = '{0, 3328, 1234, 5, 0};
  int corner_b [5] = '{1, 0, 1234, 3328, 3328};
  int corner_e [5] = '{3328, 3328, 0, 6, 1};

  initial begin
    int o0, o1, d0, d1, n;
    for (int i = 0; i < NC; i++) begin
      mem_a[i] = 12'd0; mem_b[i] = 12'd0;
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_state");

    // No start: everything stays at zero.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check_zero("idle_zero");
    end

    // Full-range sweep.
    for (int i = 0; i < NC; i++) begin
      mem_a[i] = 12'(i); mem_b[i] = 12'((2 * i) % QQ);
    end
    run_op("sweep");
    check_run("sweep");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("sweep_i0_lat%0d", lat_of(g)), 32'(got[g][0]), 32'd0);
      chk($sformatf("sweep_i1_lat%0d", lat_of(g)), 32'(got[g][1]), 32'd3328);
      chk($sformatf("sweep_i128_lat%0d", lat_of(g)), 32'(got[g][128]), 32'd3201);
      chk($sformatf("sweep_i255_lat%0d", lat_of(g)), 32'(got[g][255]), 32'd3074);
    end

    // Corner values at indices 0..4, random elsewhere.
    for (int i = 0; i < NC; i++) begin
      mem_a[i] = 12'($urandom_range(0, QQ - 1)); mem_b[i] = 12'($urandom_range(0, QQ - 1));
    end
    for (int i = 0; i < 5; i++) begin
      mem_a[i] = 12'(corner_a[i]); mem_b[i] = 12'(corner_b[i]);
    end
    run_op("corner");
    check_run("corner");
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 5; i++)
        chk($sformatf("corner%0d_lat%0d", i, lat_of(g)), 32'(got[g][i]), 32'(corner_e[i]));

    // Fully random operands.
    for (int i = 0; i < NC; i++) begin
      mem_a[i] = 12'($urandom_range(0, QQ - 1)); mem_b[i] = 12'($urandom_range(0, QQ - 1));
    end
    run_op("random");
    check_run("random");

    // start held high for 300 cycles: exactly two back-to-back operations per instance.
    o0 = ops[0]; o1 = ops[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
    tick();
    start = 1'b1;
    repeat (300) tick();
    start = 1'b0;
    n = 0;
    while ((busy_s[0] || busy_s[1]) && (n < 800)) begin
      @(negedge clk);
      n++;
    end
    chk("held_start_finish", 32'(n < 800), 32'd1);
    chk("held_start_ops_lat1", 32'(ops[0] - o0), 32'd2);
    chk("held_start_ops_lat3", 32'(ops[1] - o1), 32'd2);
    chk("held_start_dones_lat1", 32'(done_cnt[0] - d0), 32'd2);
    chk("held_start_dones_lat3", 32'(done_cnt[1] - d1), 32'd2);

    // Reset in cycle 100 of an operation.
    for (int i = 0; i < NC; i++) begin
      mem_a[i] = 12'($urandom_range(0, QQ - 1)); mem_b[i] = 12'($urandom_range(0, QQ - 1));
    end
    d0 = done_cnt[0]; d1 = done_cnt[1];
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk($sformatf("midrst_quiet_lat%0d", lat_of(g)),
          {28'd0, rd_en_s[g], wr_en_s[g], busy_s[g], done_s[g]}, 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done_lat1", 32'(done_cnt[0] - d0), 32'd0);
    chk("midrst_no_done_lat3", 32'(done_cnt[1] - d1), 32'd0);
    run_op("after_rst");
    check_run("after_rst");

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
